// File: rtl/cdu_angle_counter.sv
// rtl/cdu_angle_counter.sv - CDU shaft-angle counter with pulse synchronizers, backlog and AGC zero
module cdu_angle_counter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ATpPGH,
    input  logic        ATmPGH,
    input  logic        AGCZ,
    input  logic        cnt_slot,
    output logic [14:0] angle,
    output logic [3:0]  pending,
    output logic        ovf,
    output logic        conflict
);

    logic [SYNC_STAGES-1:0] p_sync_q, m_sync_q, z_sync_q;
    logic                   p_prev_q, m_prev_q;

    logic [14:0] angle_q, angle_d;
    logic [3:0]  pending_q, pending_d;
    logic        ovf_q, ovf_d;
    logic        conflict_q, conflict_d;

    logic              p_lvl, m_lvl, z_lvl;
    logic              p_edge, m_edge;
    logic signed [4:0] edge_step, drain_step, pend_ext, pend_drained, pend_sum;
    logic signed [4:0] angle_step;

    // Synchronizer chains and edge-detect history; prev keeps tracking during AGCZ
    always_ff @(posedge clk) begin
        if (rst) begin
            p_sync_q <= '0;
            m_sync_q <= '0;
            z_sync_q <= '0;
            p_prev_q <= 1'b0;
            m_prev_q <= 1'b0;
        end else begin
            p_sync_q <= {p_sync_q[SYNC_STAGES-2:0], ATpPGH};
            m_sync_q <= {m_sync_q[SYNC_STAGES-2:0], ATmPGH};
            z_sync_q <= {z_sync_q[SYNC_STAGES-2:0], AGCZ};
            p_prev_q <= p_sync_q[SYNC_STAGES-1];
            m_prev_q <= m_sync_q[SYNC_STAGES-1];
        end
    end

    // Next-state: edge/drain arithmetic, bypass, backlog bound and zero command
    always_comb begin
        angle_d      = angle_q;
        pending_d    = pending_q;
        ovf_d        = ovf_q;
        conflict_d   = conflict_q;

        p_lvl        = p_sync_q[SYNC_STAGES-1];
        m_lvl        = m_sync_q[SYNC_STAGES-1];
        z_lvl        = z_sync_q[SYNC_STAGES-1];
        p_edge       = p_lvl & ~p_prev_q;
        m_edge       = m_lvl & ~m_prev_q;

        if (p_edge && !m_edge)
            edge_step = 5'sd1;
        else if (m_edge && !p_edge)
            edge_step = -5'sd1;
        else
            edge_step = 5'sd0;

        if (cnt_slot && (pending_q != 4'd0))
            drain_step = pending_q[3] ? -5'sd1 : 5'sd1;
        else
            drain_step = 5'sd0;

        pend_ext     = {pending_q[3], pending_q};
        pend_drained = pend_ext - drain_step;
        pend_sum     = pend_drained + edge_step;
        angle_step   = drain_step;

        if (z_lvl) begin
            angle_d   = 15'd0;
            pending_d = 4'd0;
        end else begin
            if (p_edge && m_edge)
                conflict_d = 1'b1;
            if (cnt_slot && (pending_q == 4'd0)) begin
                // Empty backlog with a strobe: the edge goes straight to the angle
                angle_step = edge_step;
            end else if ((pend_sum > 5'sd7) || (pend_sum < -5'sd8)) begin
                pending_d = pend_drained[3:0];
                ovf_d     = 1'b1;
            end else begin
                pending_d = pend_sum[3:0];
            end
            angle_d = angle_q + {{10{angle_step[4]}}, angle_step};
        end
    end

    // Architectural state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            angle_q    <= 15'd0;
            pending_q  <= 4'd0;
            ovf_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            angle_q    <= angle_d;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
            conflict_q <= conflict_d;
        end
    end

    assign angle    = angle_q;
    assign pending  = pending_q;
    assign ovf      = ovf_q;
    assign conflict = conflict_q;

endmodule

// File: doc/cdu_angle_counter.md
CDU_ANGLE_COUNTER -- requirements
Module: cdu_angle_counter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flop stages in each pulse-input synchronizer (legal values 2..4).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 ATpPGH  input  1  asynchronous "+1 increment" pulse line from the CDU.
REQ-005 ATmPGH  input  1  asynchronous "-1 increment" pulse line from the CDU.
REQ-006 AGCZ  input  1  asynchronous zero command from the AGC, level-active.
REQ-007 cnt_slot  input  1  synchronous one-cycle counter-slot strobe; one angle step is permitted per strobe.
REQ-008 angle  output  15  accumulated shaft angle, unsigned modulo 2^15, LSB = 360/32768 deg.
REQ-009 pending  output  4  signed two's-complement backlog of unapplied increments, range -8..+7.
REQ-010 ovf  output  1  sticky flag: an increment was dropped because the backlog was full.
REQ-011 conflict  output  1  sticky flag: + and - edges were detected in the same cycle.

Function
REQ-012 ATpPGH, ATmPGH and AGCZ SHALL each pass through a SYNC_STAGES-deep synchronizer before use.
REQ-013 A pulse SHALL be one rising edge of the synchronized line; a held-high line SHALL count once only.
REQ-014 Latency: an input rising edge SHALL change pending exactly SYNC_STAGES+1 cycles later.
REQ-015 A + edge SHALL request pending +1, and a - edge SHALL request pending -1.
REQ-016 Simultaneous + and - edges SHALL cancel (net 0 change to pending) and SHALL set conflict.
REQ-017 Drain: when cnt_slot=1 and pending != 0, angle SHALL step by sign(pending) and pending SHALL move one toward zero, in the same cycle.
REQ-018 When cnt_slot=1 and pending=0 with no edge in that cycle, angle and pending SHALL hold.
REQ-019 Drain and an edge in the same cycle SHALL both apply; pending_next = pending - drain_step + edge_step.
REQ-020 The same-cycle bypass SHALL apply: with pending=0, cnt_slot=1 and a + edge, angle SHALL increment and pending SHALL stay 0 (symmetrically for a - edge).
REQ-021 Backlog bound: an edge that would push pending_next above +7 or below -8 SHALL be discarded; pending SHALL take its value without that edge, and ovf SHALL be set.
REQ-022 Wrap-around: angle 32767 stepped +1 SHALL become 0; angle 0 stepped -1 SHALL become 32767; wrap SHALL NOT set any flag.
REQ-023 While synchronized AGCZ=1: angle SHALL be forced to 0, pending SHALL be forced to 0, and edges SHALL be discarded without setting ovf or conflict.
REQ-024 While synchronized AGCZ=1, edge detection SHALL continue to track line levels, so a line already high when AGCZ falls SHALL NOT count.
REQ-025 Sticky flags (ovf, conflict) SHALL be cleared only by rst; AGCZ SHALL NOT clear them.
REQ-026 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 When rst=1 at a clock edge: angle=0, pending=0, ovf=0, conflict=0, all synchronizer and edge-detect flops cleared.
REQ-028 A line held high through the deassertion of rst SHALL produce one edge after SYNC_STAGES+1 cycles; this is the accepted start-up behaviour.
REQ-029 rst asserted mid-drain SHALL discard the backlog, with no partial update of angle.

Verification
REQ-030 Single pulse: after reset, one 3-cycle ATpPGH pulse, cnt_slot=0 -> pending=1 at cycle SYNC_STAGES+1 after the edge; then one cnt_slot -> angle=1, pending=0.
REQ-031 Burst and drain: 10 + pulses with cnt_slot=0 -> pending=7, ovf=1; then 7 strobes -> angle=7, pending=0, ovf still 1.
REQ-032 Wrap: preload via 1 - pulse with strobe from angle=0 -> angle=32767; then 1 + pulse with strobe -> angle=0, no flags set.
REQ-033 Conflict: ATpPGH and ATmPGH rising in the same cycle -> pending unchanged, conflict=1; a later rst -> conflict=0.
REQ-034 Zero command: angle=100, AGCZ held high with + pulses arriving -> angle=0 and pending=0 within SYNC_STAGES+1 cycles; pulses ignored, flags unchanged; after AGCZ falls, a new pulse with strobe -> angle=1.
REQ-035 Bypass and simultaneity: pending=0, cnt_slot coincident with a synchronized - edge -> angle decrements by 1 in that cycle, pending stays 0.
